gt_reset_sequencer: RTL and testbench

GT_RESET_SEQUENCER -- requirements
Module: gt_reset_sequencer

---
 rtl/rifl_gt_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/gt_reset_sequencer.sv | 123 ++++++++++++
 tb/tb_gt_reset_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rifl_gt_pkg.sv
// Shared types and constants for the GT reset sequencer.
package rifl_gt_pkg;

    localparam int unsigned GT_RST_CNT_W = 21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_ALL,
        ST_WAIT_CLK,
        ST_WAIT_DONE,
        ST_READY,
        ST_FAULT
    } gt_rst_state_t;

    // gt_reset_all is released only while the transceiver is being brought up or is up.
    function automatic logic gt_reset_active(input gt_rst_state_t s);
        return !(s inside {ST_WAIT_CLK, ST_WAIT_DONE, ST_READY});
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high clear.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic r_meta;
    (* ASYNC_REG = "TRUE" *) logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gt_reset_sequencer.sv
// GT bring-up and recovery sequencer on the free-running init clock.
// Define RIFL_GT_RESET_RETRY_EN to enable WAIT-state timeouts, retries and the FAULT state.
module gt_reset_sequencer
    import rifl_gt_pkg::*;
#(
    parameter int unsigned RESET_PULSE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 1048576,
    parameter int unsigned MAX_RETRY          = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gt_powergood,
    input  logic       usrclk_active,
    input  logic       tx_reset_done,
    input  logic       rx_reset_done,
    output logic       gt_reset_all,
    output logic       datapath_rst,
    output logic       gt_ready,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    localparam int unsigned PULSE_W = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE_CYCLES - 1);

    if (RESET_PULSE_CYCLES < 1 || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > (1 << GT_RST_CNT_W) || MAX_RETRY > 3) begin : g_cfg_check
        $error("gt_reset_sequencer: illegal parameter set");
    end

    logic w_pg, w_usrclk, w_tx_done, w_rx_done;

    sync_2ff u_sync_pg     (.i_clk(clk), .i_rst(rst), .i_d(gt_powergood),  .o_q(w_pg));
    sync_2ff u_sync_usrclk (.i_clk(clk), .i_rst(rst), .i_d(usrclk_active), .o_q(w_usrclk));
    sync_2ff u_sync_tx     (.i_clk(clk), .i_rst(rst), .i_d(tx_reset_done), .o_q(w_tx_done));
    sync_2ff u_sync_rx     (.i_clk(clk), .i_rst(rst), .i_d(rx_reset_done), .o_q(w_rx_done));

    gt_rst_state_t      r_state, w_next;
    logic [PULSE_W-1:0] r_pulse_cnt;
    logic               w_pulse_done, w_timeout, w_retry_left;
    logic               r_gt_reset_all, r_datapath_rst, r_gt_ready;

    assign w_pulse_done = (r_pulse_cnt == PULSE_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_pg) w_next = ST_RESET_ALL;
            ST_RESET_ALL: if (!w_pg) w_next = ST_IDLE;
                          else if (w_pulse_done) w_next = ST_WAIT_CLK;
            ST_WAIT_CLK:  if (!w_pg) w_next = ST_IDLE;
                          else if (w_usrclk) w_next = ST_WAIT_DONE;
                          else if (w_timeout) w_next = w_retry_left ? ST_RESET_ALL : ST_FAULT;
            ST_WAIT_DONE: if (!w_pg) w_next = ST_IDLE;
                          else if (w_tx_done && w_rx_done) w_next = ST_READY;
                          else if (w_timeout) w_next = w_retry_left ? ST_RESET_ALL : ST_FAULT;
            ST_READY:     if (!w_pg) w_next = ST_IDLE;
                          else if (!w_usrclk || !w_tx_done || !w_rx_done) w_next = ST_RESET_ALL;
            ST_FAULT:     w_next = ST_FAULT;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pulse_cnt    <= '0;
            r_gt_reset_all <= 1'b1;
            r_datapath_rst <= 1'b1;
            r_gt_ready     <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_pulse_cnt    <= (r_state == ST_RESET_ALL && w_next == ST_RESET_ALL) ?
                              r_pulse_cnt + PULSE_W'(1) : '0;
            r_gt_reset_all <= gt_reset_active(w_next);
            r_datapath_rst <= (w_next != ST_READY);
            r_gt_ready     <= (w_next == ST_READY);
        end
    end

    assign gt_reset_all = r_gt_reset_all;
    assign datapath_rst = r_datapath_rst;
    assign gt_ready     = r_gt_ready;

`ifdef RIFL_GT_RESET_RETRY_EN
    localparam logic [GT_RST_CNT_W-1:0] WAIT_LAST   = GT_RST_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]              MAX_RETRY_2 = 2'(MAX_RETRY);

    logic [GT_RST_CNT_W-1:0] r_wait_cnt;
    logic [1:0]              r_retry_cnt;
    logic                    r_fault;
    logic                    w_in_wait, w_retry_inc;

    assign w_in_wait    = (r_state == ST_WAIT_CLK) || (r_state == ST_WAIT_DONE);
    // A WAIT state only returns to RESET_ALL through a timeout with retries left.
    assign w_retry_inc  = w_in_wait && (w_next == ST_RESET_ALL);
    assign w_timeout    = (r_wait_cnt == WAIT_LAST);
    assign w_retry_left = (r_retry_cnt < MAX_RETRY_2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_retry_cnt <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_wait_cnt <= (w_in_wait && w_next == r_state) ? r_wait_cnt + GT_RST_CNT_W'(1) : '0;
            if (w_retry_inc && r_retry_cnt != 2'd3)
                r_retry_cnt <= r_retry_cnt + 2'd1;
            r_fault <= (w_next == ST_FAULT);
        end
    end

    assign fault     = r_fault;
    assign retry_cnt = r_retry_cnt;
`else
    assign w_timeout    = 1'b0;
    assign w_retry_left = 1'b0;
    assign fault        = 1'b0;
    assign retry_cnt    = 2'b00;
`endif

endmodule

// File: tb/tb_gt_reset_sequencer.sv
// Directed bench with randomized timing for gt_reset_sequencer; expected delays come from event arithmetic.
// Honours RIFL_GT_RESET_RETRY_EN to select the timeout/retry or the wait-forever scenario.
module tb_gt_reset_sequencer;

    localparam int P   = 4;
    localparam int T   = 100;
    localparam int MR  = 3;
    // Input change -> two sync stages -> one decision cycle -> registered output.
    localparam int LAT = 3;

    localparam int SEL_GRA = 0;
    localparam int SEL_DPR = 1;
    localparam int SEL_RDY = 2;
    localparam int SEL_FLT = 3;
    localparam int SEL_RC  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pg = 1'b0, uc = 1'b0, txd = 1'b0, rxd = 1'b0;
    logic       gra, dpr, rdy, flt;
    logic [1:0] rc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gt_reset_sequencer #(
        .RESET_PULSE_CYCLES(P),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gt_powergood(pg),
        .usrclk_active(uc),
        .tx_reset_done(txd),
        .rx_reset_done(rxd),
        .gt_reset_all(gra),
        .datapath_rst(dpr),
        .gt_ready(rdy),
        .fault(flt),
        .retry_cnt(rc)
    );

    function automatic logic [31:0] out_val(input int sel);
        case (sel)
            SEL_GRA: return {31'd0, gra};
            SEL_DPR: return {31'd0, dpr};
            SEL_RDY: return {31'd0, rdy};
            SEL_FLT: return {31'd0, flt};
            default: return {30'd0, rc};
        endcase
    endfunction

    // Delay from restoring a dropped READY condition until gt_ready returns:
    // a usrclk loss re-enters via WAIT_CLK and needs one extra state hop.
    function automatic int ready_after_restore(input int dropped);
        return (dropped == 0) ? LAT + 1 : LAT;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for(input int sel, input logic [31:0] val, input int budget, output int elapsed);
        elapsed = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (out_val(sel) === val) begin
                elapsed = i;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gt_reset_all"}, out_val(SEL_GRA), 1);
        check({tag, "_datapath_rst"}, out_val(SEL_DPR), 1);
        check({tag, "_gt_ready"},     out_val(SEL_RDY), 0);
        check({tag, "_fault"},        out_val(SEL_FLT), 0);
        check({tag, "_retry_cnt"},    out_val(SEL_RC),  0);
    endtask

    initial begin
        int e, d, len, sel, seen_rdy, bad;

        // Reset state
        step(3);
        check_reset_vals("reset");
        rst = 1'b0;
        step($urandom_range(3, 12));
        check("idle_gt_reset_all", out_val(SEL_GRA), 1);
        check("idle_datapath_rst", out_val(SEL_DPR), 1);

        // Nominal bring-up with random gaps between events
        pg = 1'b1;
        wait_for(SEL_GRA, 0, 50, e);
        check("bringup_pulse_end", e, LAT + P);
        step($urandom_range(2, 30));
        uc = 1'b1;
        step($urandom_range(LAT + 2, 40));
        txd = 1'b1;
        rxd = 1'b1;
        wait_for(SEL_RDY, 1, 20, e);
        check("bringup_ready_delay", e, LAT);
        check("bringup_datapath_rst", out_val(SEL_DPR), 0);
        check("bringup_gt_reset_all", out_val(SEL_GRA), 0);
        check("bringup_retry_cnt", out_val(SEL_RC), 0);
        check("bringup_fault", out_val(SEL_FLT), 0);

        // Loss of a READY condition for a random length
        for (int it = 0; it < 3; it++) begin
            sel = (it == 1) ? 2 : $urandom_range(0, 2);
            len = $urandom_range(12, 40);
            case (sel)
                0: uc = 1'b0;
                1: txd = 1'b0;
                default: rxd = 1'b0;
            endcase
            wait_for(SEL_RDY, 0, 10, e);
            check("loss_ready_fall", e, LAT);
            check("loss_datapath_rst", out_val(SEL_DPR), 1);
            wait_for(SEL_GRA, 0, 20, e);
            check("loss_pulse_len", e, P);
            step(len - LAT - P);
            uc = 1'b1;
            txd = 1'b1;
            rxd = 1'b1;
            wait_for(SEL_RDY, 1, 20, e);
            check("loss_ready_regain", e, ready_after_restore(sel));
            check("loss_retry_cnt", out_val(SEL_RC), 0);
        end

        // Reset while READY
        rst = 1'b1;
        step(1);
        check_reset_vals("rst_in_ready");

        // Powergood loss in the same cycle the dones rise in WAIT_DONE
        txd = 1'b0;
        rxd = 1'b0;
        rst = 1'b0;
        wait_for(SEL_GRA, 0, 30, e);
        check("pgloss_pulse_end", e, LAT + P);
        step(4);
        pg  = 1'b0;
        txd = 1'b1;
        rxd = 1'b1;
        seen_rdy = 0;
        e = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (rdy !== 1'b0) seen_rdy = 1;
            if (e < 0 && gra === 1'b1) e = i;
        end
        check("pgloss_ready_stays_low", seen_rdy, 0);
        check("pgloss_back_to_idle", e, LAT);
        check("pgloss_idle_reset_all", out_val(SEL_GRA), 1);

        // Reset during the second cycle of the reset pulse
        pg = 1'b1;
        step(LAT + 1);
        rst = 1'b1;
        step(1);
        check_reset_vals("rst_mid_pulse");
        rst = 1'b0;
        wait_for(SEL_GRA, 0, 30, e);
        check("after_rst_pulse_end", e, LAT + P);
        wait_for(SEL_RDY, 1, 20, e);
        check("after_rst_ready", e, 2);

`ifdef RIFL_GT_RESET_RETRY_EN
        // usrclk never rises: three retries, then FAULT until reset
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        uc  = 1'b0;
        txd = 1'b0;
        rxd = 1'b0;
        wait_for(SEL_GRA, 0, 30, e);
        check("retry_pulse_end", e, LAT + P);
        wait_for(SEL_RC, 1, T + 20, e);
        check("retry1_delay", e, T);
        check("retry1_gt_reset_all", out_val(SEL_GRA), 1);
        wait_for(SEL_RC, 2, T + P + 20, e);
        check("retry2_delay", e, T + P);
        wait_for(SEL_RC, 3, T + P + 20, e);
        check("retry3_delay", e, T + P);
        wait_for(SEL_FLT, 1, T + P + 20, e);
        check("fault_delay", e, T + P);
        check("fault_gt_reset_all", out_val(SEL_GRA), 1);
        check("fault_datapath_rst", out_val(SEL_DPR), 1);
        check("fault_gt_ready", out_val(SEL_RDY), 0);
        check("fault_retry_cnt", out_val(SEL_RC), MR);
        pg = 1'b0;
        uc = 1'b1;
        step(30);
        check("fault_sticky", out_val(SEL_FLT), 1);
        check("fault_sticky_reset_all", out_val(SEL_GRA), 1);
        rst = 1'b1;
        step(1);
        check_reset_vals("rst_in_fault");
        rst = 1'b0;
        pg  = 1'b1;
        txd = 1'b1;
        rxd = 1'b1;
        wait_for(SEL_RDY, 1, 40, e);
        check("after_fault_ready", e, LAT + P + 2);
`else
        // usrclk held low for a long time: no timeout, no fault
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        uc  = 1'b0;
        wait_for(SEL_GRA, 0, 30, e);
        check("nowait_pulse_end", e, LAT + P);
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            step(1);
            if (gra !== 1'b0 || dpr !== 1'b1 || rdy !== 1'b0 || flt !== 1'b0 || rc !== 2'd0)
                bad++;
        end
        check("nowait_stays_in_wait_clk", bad, 0);
        uc = 1'b1;
        wait_for(SEL_RDY, 1, 20, e);
        check("nowait_ready_after_usrclk", e, LAT + 1);
        check("nowait_fault", out_val(SEL_FLT), 0);
        check("nowait_retry_cnt", out_val(SEL_RC), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
